// File: rtl/ucsbece152a_ctrl_pkg.sv
// Shared types for the counter run/pause/step controller.
package ucsbece152a_ctrl_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10
  } ctrl_state_t;

endpackage

// File: rtl/ucsbece152a_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability filter, one-cycle press pulse.
// press_o rises DEBOUNCE+2 cycles after the raw input settles high.
module ucsbece152a_debounce #(
  parameter int DEBOUNCE = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronized input has disagreed with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ucsbece152a_counter_ctrl.sv
// Run/pause/step controller producing enable/direction for ucsbece152a_counter.
// All outputs registered; count_i is the counter's value fed back.
module ucsbece152a_counter_ctrl #(
  parameter int WIDTH    = 3,
  parameter int DIV      = 50_000_000,
  parameter int DEBOUNCE = 500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_btn_i,
  input  logic             step_btn_i,
  input  logic             dir_btn_i,
  input  logic             bounce_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             enable_o,
  output logic             dir_o,
  output logic [1:0]       state_o
);
  import ucsbece152a_ctrl_pkg::*;

  localparam int PW = $clog2(DIV);

  logic          run_press, step_press, dir_press;
  ctrl_state_t   state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          enable_q, enable_d;
  logic          dir_q, dir_d;
  logic          bounce_s1_q, bounce_s2_q;
  logic          tick;

  ucsbece152a_debounce #(.DEBOUNCE(DEBOUNCE)) u_run_db (
    .clk(clk), .rst(rst), .btn_i(run_btn_i), .press_o(run_press)
  );
  ucsbece152a_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clk(clk), .rst(rst), .btn_i(step_btn_i), .press_o(step_press)
  );
  ucsbece152a_debounce #(.DEBOUNCE(DEBOUNCE)) u_dir_db (
    .clk(clk), .rst(rst), .btn_i(dir_btn_i), .press_o(dir_press)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      PAUSED: begin
        if (run_press)       state_d = RUN;
        else if (step_press) state_d = STEP;
      end
      RUN:     if (run_press) state_d = PAUSED;
      STEP:    state_d = PAUSED;
      default: state_d = PAUSED;
    endcase
  end

  assign tick = (state_q == RUN) && (presc_q == PW'(DIV - 1));

  // Zeroing on exit guarantees every RUN entry starts a full period.
  always_comb begin
    presc_d = '0;
    if (state_q == RUN && state_d == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
  end

  assign enable_d = tick || (state_q == STEP);

  // Limit reversal beats a same-cycle dir press, which is dropped.
  always_comb begin
    dir_d = dir_q;
    if (bounce_s2_q && dir_q && (count_i == {WIDTH{1'b1}})) begin
      dir_d = 1'b0;
    end else if (bounce_s2_q && !dir_q && (count_i == '0)) begin
      dir_d = 1'b1;
    end else if (dir_press) begin
      dir_d = ~dir_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= PAUSED;
      presc_q     <= '0;
      enable_q    <= 1'b0;
      dir_q       <= 1'b1;
      bounce_s1_q <= 1'b0;
      bounce_s2_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      enable_q    <= enable_d;
      dir_q       <= dir_d;
      bounce_s1_q <= bounce_i;
      bounce_s2_q <= bounce_s1_q;
    end
  end

  assign enable_o = enable_q;
  assign dir_o    = dir_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_ucsbece152a_counter_ctrl.sv
// Bench for ucsbece152a_counter_ctrl with a behavioural counter closing the count_i loop.
// Expected behaviour is derived from press timing, pulse period and a triangle-wave count model.
module tb_ucsbece152a_counter_ctrl;

  localparam int WIDTH    = 3;
  localparam int DIV      = 4;
  localparam int DEBOUNCE = 3;
  // Raw button edge to state change: two sync stages, DEBOUNCE samples, one press register, state register.
  localparam int LAT      = DEBOUNCE + 3;
  localparam int LIM      = (1 << WIDTH) - 1;
  localparam logic [1:0] S_PAUSED = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_STEP   = 2'b10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             run_btn = 1'b0, step_btn = 1'b0, dir_btn = 1'b0, bounce = 1'b0;
  logic [WIDTH-1:0] count;
  logic             enable_o, dir_o;
  logic [1:0]       state_o;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  int exp_cnt = 0;

  ucsbece152a_counter_ctrl #(.WIDTH(WIDTH), .DIV(DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst),
    .run_btn_i(run_btn), .step_btn_i(step_btn), .dir_btn_i(dir_btn), .bounce_i(bounce),
    .count_i(count), .enable_o(enable_o), .dir_o(dir_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Behavioural up/down counter standing in for ucsbece152a_counter.
  always @(posedge clk or negedge rst) begin
    if (!rst)          count <= '0;
    else if (enable_o) count <= dir_o ? count + 1'b1 : count - 1'b1;
  end

  function automatic int tri_count(input int m);
    int p;
    p = m % (2 * LIM);
    return (p <= LIM) ? p : 2 * LIM - p;
  endfunction

  function automatic logic tri_dir(input int m);
    return ((m % (2 * LIM)) < LIM) ? 1'b1 : 1'b0;
  endfunction

  // Pulses n >= 1 (at cycles e + n*DIV) whose effect is visible lag cycles later, by cycle c.
  function automatic int pulses_by(input int c, input int e, input int lag);
    if (c - e - lag < 0) return 0;
    return (c - e - lag) / DIV;
  endfunction

  function automatic logic run_en(input int c, input int e);
    return (c > e) && ((c - e) % DIV == 0);
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       run_btn  = v;
      1:       step_btn = v;
      default: dir_btn  = v;
    endcase
  endtask

  task automatic press_btn(input int which, input int hold);
    set_btn(which, 1'b1);
    for (int k = 0; k < hold; k++) nxt();
    set_btn(which, 1'b0);
    for (int k = 0; k < LAT; k++) nxt();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_btn = 1'($urandom); step_btn = 1'($urandom);
      dir_btn = 1'($urandom); bounce = 1'($urandom);
      nxt();
      tests++;
      if (state_o !== S_PAUSED || enable_o !== 1'b0 || dir_o !== 1'b1) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: state=%b en=%b dir=%b, want 00/0/1", cyc_n, state_o, enable_o, dir_o);
      end
    end
    run_btn = 1'b0; step_btn = 1'b0; dir_btn = 1'b0; bounce = 1'b0;
    nxt();
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      nxt();
      tests++;
      if (state_o !== S_PAUSED || enable_o !== 1'b0 || dir_o !== 1'b1) begin
        fails++;
        $display("FAIL reset_release cyc %0d: state=%b en=%b dir=%b, want 00/0/1", cyc_n, state_o, enable_o, dir_o);
      end
    end
  endtask

  task automatic test_run();
    int hold, n, c0, e, x;
    logic [1:0] exp_st;
    logic exp_en;
    hold = $urandom_range(10, DEBOUNCE);
    n    = $urandom_range(9, 3);
    c0 = cyc_n; e = c0 + LAT;
    run_btn = 1'b1;
    for (int k = 1; k <= LAT + n * DIV; k++) begin
      nxt();
      if (k == hold) run_btn = 1'b0;
      exp_st = (cyc_n >= e) ? S_RUN : S_PAUSED;
      exp_en = run_en(cyc_n, e);
      tests++;
      if (state_o !== exp_st || enable_o !== exp_en || dir_o !== 1'b1) begin
        fails++;
        $display("FAIL run_start cyc %0d: state=%b en=%b dir=%b, want %b/%b/1", cyc_n, state_o, enable_o, dir_o, exp_st, exp_en);
      end
    end
    hold = $urandom_range(6, DEBOUNCE);
    x = cyc_n + LAT;
    run_btn = 1'b1;
    for (int k = 1; k <= LAT + 2 * DIV; k++) begin
      nxt();
      if (k == hold) run_btn = 1'b0;
      exp_st = (cyc_n >= x) ? S_PAUSED : S_RUN;
      exp_en = (cyc_n <= x) && run_en(cyc_n, e);
      tests++;
      if (state_o !== exp_st || enable_o !== exp_en) begin
        fails++;
        $display("FAIL run_stop cyc %0d: state=%b en=%b, want %b/%b", cyc_n, state_o, enable_o, exp_st, exp_en);
      end
    end
    exp_cnt = pulses_by(x, e, 0) % (LIM + 1);
    tests++;
    if (count !== WIDTH'(exp_cnt)) begin
      fails++;
      $display("FAIL run_count: count=%0d, want %0d", count, exp_cnt);
    end
  endtask

  task automatic test_glitch();
    int which, len;
    for (int t = 0; t < 4; t++) begin
      which = $urandom_range(2, 0);
      len   = $urandom_range(DEBOUNCE - 1, 1);
      set_btn(which, 1'b1);
      for (int k = 1; k <= len + 12; k++) begin
        nxt();
        if (k == len) set_btn(which, 1'b0);
        tests++;
        if (state_o !== S_PAUSED || enable_o !== 1'b0 || dir_o !== 1'b1) begin
          fails++;
          $display("FAIL glitch btn%0d len%0d cyc %0d: state=%b en=%b dir=%b, want 00/0/1", which, len, cyc_n, state_o, enable_o, dir_o);
        end
      end
    end
  endtask

  task automatic test_step();
    int hold, c0, s, e, ks, hs, x;
    logic [1:0] exp_st;
    logic exp_en;
    hold = $urandom_range(8, DEBOUNCE);
    c0 = cyc_n; s = c0 + LAT;
    step_btn = 1'b1;
    for (int k = 1; k <= LAT + 6; k++) begin
      nxt();
      if (k == hold) step_btn = 1'b0;
      exp_st = (cyc_n == s) ? S_STEP : S_PAUSED;
      exp_en = (cyc_n == s + 1);
      tests++;
      if (state_o !== exp_st || enable_o !== exp_en) begin
        fails++;
        $display("FAIL step_paused cyc %0d: state=%b en=%b, want %b/%b", cyc_n, state_o, enable_o, exp_st, exp_en);
      end
    end
    exp_cnt = (exp_cnt + 1) % (LIM + 1);
    tests++;
    if (count !== WIDTH'(exp_cnt)) begin
      fails++;
      $display("FAIL step_count: count=%0d, want %0d", count, exp_cnt);
    end
    hold = $urandom_range(8, DEBOUNCE);
    ks = LAT + 1 + $urandom_range(7, 0);
    hs = $urandom_range(5, DEBOUNCE);
    c0 = cyc_n; e = c0 + LAT;
    run_btn = 1'b1;
    for (int k = 1; k <= LAT + 6 * DIV; k++) begin
      nxt();
      if (k == hold)    run_btn  = 1'b0;
      if (k == ks)      step_btn = 1'b1;
      if (k == ks + hs) step_btn = 1'b0;
      exp_st = (cyc_n >= e) ? S_RUN : S_PAUSED;
      exp_en = run_en(cyc_n, e);
      tests++;
      if (state_o !== exp_st || enable_o !== exp_en) begin
        fails++;
        $display("FAIL step_in_run cyc %0d: state=%b en=%b, want %b/%b", cyc_n, state_o, enable_o, exp_st, exp_en);
      end
    end
    x = cyc_n + LAT;
    press_btn(0, DEBOUNCE);
    exp_cnt = (exp_cnt + pulses_by(x, e, 0)) % (LIM + 1);
    tests++;
    if (count !== WIDTH'(exp_cnt) || state_o !== S_PAUSED) begin
      fails++;
      $display("FAIL step_run_count: count=%0d state=%b, want %0d/00", count, state_o, exp_cnt);
    end
  endtask

  task automatic test_dir();
    int c0;
    logic exp_dir;
    for (int t = 0; t < 2; t++) begin
      c0 = cyc_n;
      dir_btn = 1'b1;
      for (int k = 1; k <= LAT + 4; k++) begin
        nxt();
        if (k == DEBOUNCE) dir_btn = 1'b0;
        exp_dir = (cyc_n >= c0 + LAT) ? (t == 0 ? 1'b0 : 1'b1) : (t == 0 ? 1'b1 : 1'b0);
        tests++;
        if (dir_o !== exp_dir || enable_o !== 1'b0) begin
          fails++;
          $display("FAIL dir_toggle%0d cyc %0d: dir=%b en=%b, want %b/0", t, cyc_n, dir_o, enable_o, exp_dir);
        end
      end
      if (t == 0) begin
        press_btn(1, DEBOUNCE);
        exp_cnt = (exp_cnt + LIM) % (LIM + 1);
        tests++;
        if (count !== WIDTH'(exp_cnt)) begin
          fails++;
          $display("FAIL dir_step_down: count=%0d, want %0d", count, exp_cnt);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int c0, e, hold, cdir, m_cnt, m_dir;
    logic [1:0] exp_st;
    logic exp_en;
    rst = 1'b0; nxt(); rst = 1'b1;
    bounce = 1'b1;
    nxt(); nxt(); nxt();
    hold = $urandom_range(8, DEBOUNCE);
    c0 = cyc_n; e = c0 + LAT;
    // Dir press timed so its pulse coincides with the cycle count 7 is first seen going up.
    cdir = e + 7 * DIV + 1 - (DEBOUNCE + 2);
    run_btn = 1'b1;
    while (cyc_n < e + 24 * DIV) begin
      nxt();
      if (cyc_n == c0 + hold)       run_btn = 1'b0;
      if (cyc_n == cdir)            dir_btn = 1'b1;
      if (cyc_n == cdir + DEBOUNCE) dir_btn = 1'b0;
      exp_st = (cyc_n >= e) ? S_RUN : S_PAUSED;
      exp_en = run_en(cyc_n, e);
      m_cnt  = pulses_by(cyc_n, e, 1);
      m_dir  = pulses_by(cyc_n, e, 2);
      tests++;
      if (state_o !== exp_st || enable_o !== exp_en || dir_o !== tri_dir(m_dir) ||
          count !== WIDTH'(tri_count(m_cnt))) begin
        fails++;
        $display("FAIL bounce cyc %0d: state=%b en=%b dir=%b count=%0d, want %b/%b/%b/%0d",
                 cyc_n, state_o, enable_o, dir_o, count, exp_st, exp_en, tri_dir(m_dir), tri_count(m_cnt));
      end
    end
  endtask

  task automatic test_reset_mid();
    int c0, e, hold, first;
    logic [1:0] exp_st;
    logic exp_en;
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (state_o !== S_PAUSED || enable_o !== 1'b0 || dir_o !== 1'b1) begin
      fails++;
      $display("FAIL reset_async: state=%b en=%b dir=%b, want 00/0/1", state_o, enable_o, dir_o);
    end
    bounce = 1'b0;
    nxt(); nxt();
    rst = 1'b1;
    hold = $urandom_range(8, DEBOUNCE);
    c0 = cyc_n; e = c0 + LAT; first = -1;
    run_btn = 1'b1;
    for (int k = 1; k <= LAT + 2 * DIV; k++) begin
      nxt();
      if (k == hold) run_btn = 1'b0;
      if (enable_o === 1'b1 && first < 0) first = cyc_n;
      exp_st = (cyc_n >= e) ? S_RUN : S_PAUSED;
      exp_en = run_en(cyc_n, e);
      tests++;
      if (state_o !== exp_st || enable_o !== exp_en || dir_o !== 1'b1) begin
        fails++;
        $display("FAIL reset_rerun cyc %0d: state=%b en=%b dir=%b, want %b/%b/1", cyc_n, state_o, enable_o, dir_o, exp_st, exp_en);
      end
    end
    // Measured from the cycle the FSM sees the run press (one before state_o shows RUN).
    tests++;
    if (first - (e - 1) != DIV + 1) begin
      fails++;
      $display("FAIL first_pulse_latency: %0d cycles, want %0d", first - (e - 1), DIV + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run();
    test_glitch();
    test_step();
    test_dir();
    test_bounce();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
